// File: rtl/ariane_pkg.sv
// Branch-prediction types exchanged between the branch unit and the BHT.
package ariane_pkg;
  typedef enum logic [2:0] {
    NoCF,
    Branch,
    Jump,
    JumpR,
    Return
  } cf_t;

  typedef struct packed {
    logic                    valid;
    logic [riscv::VLEN-1:0]  pc;
    logic [riscv::VLEN-1:0]  target_address;
    logic                    is_mispredict;
    logic                    is_taken;
    cf_t                     cf_type;
  } bp_resolve_t;

  typedef struct packed {
    logic                    valid;
    logic [riscv::VLEN-1:0]  pc;
    logic                    taken;
  } bht_update_t;
endpackage

// File: rtl/riscv_pkg.sv
// Core-wide RISC-V architectural constants shared by the front-end blocks.
package riscv;
  localparam int unsigned VLEN = 64;
endpackage

// File: rtl/bht_update_queue.sv
// Buffers resolved conditional-branch outcomes for the BHT, coalescing repeat
// updates to the youngest entry and counting outcomes lost to overflow.
module bht_update_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       debug_mode_i,
  input  bp_resolve_t                resolved_branch_i,
  input  logic                       update_stall_i,
  output bht_update_t                bht_update_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic [CNT_WIDTH-1:0]       drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [riscv::VLEN-1:0] r_pc    [DEPTH];
  logic                   r_taken [DEPTH];
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [LVL_W-1:0]       r_level;
  logic [CNT_WIDTH-1:0]   r_drop_cnt;

  logic                   w_empty;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_accept;
  logic [PTR_W-1:0]       w_tail;
  logic                   w_tail_popped;
  logic                   w_coalesce;
  logic                   w_push;
  logic                   w_drop;
  logic                   w_unused;

  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LVL_W'(DEPTH));
  assign w_pop    = !w_empty && !update_stall_i && !flush_i;
  assign w_accept = resolved_branch_i.valid && (resolved_branch_i.cf_type == Branch)
                    && !debug_mode_i && !flush_i;

  // With a single entry the youngest is also the head; once it pops it can no
  // longer absorb an overwrite, so a matching outcome becomes a fresh entry.
  assign w_tail        = r_wr_ptr - PTR_W'(1);
  assign w_tail_popped = w_pop && (r_level == LVL_W'(1));
  assign w_coalesce    = w_accept && !w_empty && !w_tail_popped
                         && (r_pc[w_tail] == resolved_branch_i.pc);
  assign w_push        = w_accept && !w_coalesce && (!w_full || w_pop);
  assign w_drop        = w_accept && !w_coalesce && w_full && !w_pop;

  assign w_unused = ^{resolved_branch_i.target_address, resolved_branch_i.is_mispredict};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_level    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (flush_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
      end
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc[r_wr_ptr]    <= resolved_branch_i.pc;
      r_taken[r_wr_ptr] <= resolved_branch_i.is_taken;
    end
    if (w_coalesce) r_taken[w_tail] <= resolved_branch_i.is_taken;
  end

  always_comb begin
    bht_update_o       = '0;
    bht_update_o.valid = w_pop;
    if (w_pop) begin
      bht_update_o.pc    = r_pc[r_rd_ptr];
      bht_update_o.taken = r_taken[r_rd_ptr];
    end
  end

  assign level_o    = r_level;
  assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_bht_update_queue.sv
// Scoreboard bench for bht_update_queue: directed stimulus queues expected
// updates, a negedge monitor pops and compares each emitted BHT update.
module tb_bht_update_queue;
  import ariane_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 4;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            debug_mode_i;
  bp_resolve_t     rb;
  logic            update_stall_i;
  bht_update_t     bht_update_o;
  logic [2:0]      level_o;
  logic [CW-1:0]   drop_cnt_o;

  int checks   = 0;
  int failures = 0;
  logic [64:0] exp_q [$];

  bht_update_queue #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .flush_i           (flush_i),
    .debug_mode_i      (debug_mode_i),
    .resolved_branch_i (rb),
    .update_stall_i    (update_stall_i),
    .bht_update_o      (bht_update_o),
    .level_o           (level_o),
    .drop_cnt_o        (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, expv);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && bht_update_o.valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_update actual=0x%0h required=none", bht_update_o.pc);
      end else begin
        check("update", {bht_update_o.pc, bht_update_o.taken}, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic acc(input logic [63:0] pc, input logic tk, input cf_t cf, input bit expect_out);
    rb.valid    = 1'b1;
    rb.pc       = pc;
    rb.is_taken = tk;
    rb.cf_type  = cf;
    if (expect_out) exp_q.push_back({pc, tk});
    step();
    rb.valid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      #2 check("drain_valid", bht_update_o.valid, 1'b1);
      step();
    end
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; debug_mode_i = 1'b0; update_stall_i = 1'b0;
    rb = '0;
    #3;
    check("rst_level", level_o, 3'd0);
    check("rst_drop", drop_cnt_o, 4'd0);
    check("rst_update", bht_update_o, '0);
    #9 rst_ni = 1'b1;
    step();

    // Single outcome: no bypass in the accept cycle, emitted next cycle
    rb.valid = 1'b1; rb.pc = 64'h80; rb.is_taken = 1'b0; rb.cf_type = Branch;
    #2 check("no_bypass", bht_update_o.valid, 1'b0);
    exp_q.push_back({64'h80, 1'b0});
    step();
    rb.valid = 1'b0;
    #2 check("single_level1", level_o, 3'd1);
    step();
    check("single_level0", level_o, 3'd0);

    // Overflow while stalled, then ordered drain
    update_stall_i = 1'b1;
    for (int i = 1; i <= 5; i++) acc(64'(i * 16), 1'(i), Branch, i <= 4);
    check("ovf_level", level_o, 3'd4);
    check("ovf_drop", drop_cnt_o, 4'd1);
    update_stall_i = 1'b0;
    drain(4);
    check("ovf_empty", level_o, 3'd0);

    // Coalesce into youngest entry
    update_stall_i = 1'b1;
    acc(64'h100, 1'b1, Branch, 1'b0);
    acc(64'h100, 1'b0, Branch, 1'b1);
    check("coal_level", level_o, 3'd1);
    update_stall_i = 1'b0;
    step();
    check("coal_empty", level_o, 3'd0);

    // Matching accept while the sole entry pops becomes a new entry
    acc(64'h200, 1'b1, Branch, 1'b1);
    acc(64'h200, 1'b0, Branch, 1'b1);
    check("popmatch_level", level_o, 3'd1);
    step();

    // Flush with simultaneous accept
    update_stall_i = 1'b1;
    acc(64'h300, 1'b0, Branch, 1'b0);
    acc(64'h304, 1'b1, Branch, 1'b0);
    acc(64'h308, 1'b0, Branch, 1'b0);
    check("flush_pre", level_o, 3'd3);
    update_stall_i = 1'b0;
    flush_i = 1'b1;
    rb.valid = 1'b1; rb.pc = 64'h30c; rb.cf_type = Branch;
    #2 check("flush_no_upd", bht_update_o.valid, 1'b0);
    step();
    flush_i = 1'b0; rb.valid = 1'b0;
    check("flush_level", level_o, 3'd0);
    check("flush_drop", drop_cnt_o, 4'd1);
    step();

    // Ignored accepts: jump, debug mode; queued entry still drains in debug
    acc(64'h400, 1'b1, Jump, 1'b0);
    check("jump_level", level_o, 3'd0);
    debug_mode_i = 1'b1;
    acc(64'h404, 1'b1, Branch, 1'b0);
    check("debug_level", level_o, 3'd0);
    debug_mode_i = 1'b0;
    update_stall_i = 1'b1;
    acc(64'h500, 1'b1, Branch, 1'b1);
    update_stall_i = 1'b0; debug_mode_i = 1'b1;
    acc(64'h504, 1'b0, Branch, 1'b0);
    debug_mode_i = 1'b0;
    check("debug_drain", level_o, 3'd0);

    // Full with simultaneous pop
    update_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) acc(64'h600 + 64'(4 * i), 1'(i), Branch, 1'b1);
    update_stall_i = 1'b0;
    acc(64'h610, 1'b1, Branch, 1'b1);
    check("fullpop_level", level_o, 3'd4);
    check("fullpop_drop", drop_cnt_o, 4'd1);
    drain(4);

    // Full with coalescing accept
    update_stall_i = 1'b1;
    for (int i = 0; i < 3; i++) acc(64'h700 + 64'(4 * i), 1'b0, Branch, 1'b1);
    acc(64'h70c, 1'b0, Branch, 1'b0);
    acc(64'h70c, 1'b1, Branch, 1'b1);
    check("fullcoal_level", level_o, 3'd4);
    check("fullcoal_drop", drop_cnt_o, 4'd1);
    update_stall_i = 1'b0;
    drain(4);

    // Drop counter saturation
    update_stall_i = 1'b1;
    for (int i = 0; i < 4; i++) acc(64'h800 + 64'(4 * i), 1'b1, Branch, 1'b1);
    for (int i = 0; i < 13; i++) acc(64'h900 + 64'(4 * i), 1'b0, Branch, 1'b0);
    check("drop_14", drop_cnt_o, 4'd14);
    acc(64'hA00, 1'b0, Branch, 1'b0);
    check("drop_15", drop_cnt_o, 4'd15);
    acc(64'hA04, 1'b0, Branch, 1'b0);
    check("drop_sat", drop_cnt_o, 4'd15);
    update_stall_i = 1'b0;
    drain(4);

    // Reset mid-operation discards entries
    update_stall_i = 1'b1;
    acc(64'hB00, 1'b1, Branch, 1'b0);
    acc(64'hB04, 1'b1, Branch, 1'b0);
    rst_ni = 1'b0;
    #2;
    check("midrst_level", level_o, 3'd0);
    check("midrst_drop", drop_cnt_o, 4'd0);
    check("midrst_update", bht_update_o, '0);
    step();
    rst_ni = 1'b1; update_stall_i = 1'b0;
    step(); step();
    check("midrst_after", level_o, 3'd0);

    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/bht_update_queue.md
BHT_UPDATE_QUEUE -- requirements
Module: bht_update_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queued branch outcomes; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of the drop counter.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port flush_i, input, 1 bit: discard all queued outcomes.
REQ-006 The block SHALL have port debug_mode_i, input, 1 bit: suppress new accepts while set.
REQ-007 The block SHALL have port resolved_branch_i, input, ariane_pkg::bp_resolve_t: resolved control-flow from the branch unit (valid, pc, is_taken, cf_type).
REQ-008 The block SHALL have port update_stall_i, input, 1 bit: the BHT cannot take an update this cycle.
REQ-009 The block SHALL have port bht_update_o, output, ariane_pkg::bht_update_t: update to the BHT (valid, pc, taken).
REQ-010 The block SHALL have port level_o, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-011 The block SHALL have port drop_cnt_o, output, CNT_WIDTH bits: saturating count of discarded outcomes.

Function
REQ-012 Accept: resolved_branch_i.valid, cf_type == ariane_pkg::Branch, !debug_mode_i and !flush_i; all other inputs SHALL be ignored.
REQ-013 Entry contents: pc (riscv::VLEN bits) and taken (= is_taken).
REQ-014 Output: bht_update_o.valid = !empty && !update_stall_i && !flush_i; pc/taken from head entry when valid, else all-zero.
REQ-015 Pop: head removed in the same cycle bht_update_o.valid is 1 (BHT always consumes a valid update).
REQ-016 Latency: an outcome accepted in cycle N SHALL appear on bht_update_o no earlier than cycle N+1 (no combinational bypass); FIFO order preserved.
REQ-017 Coalesce: accepted pc equal to the youngest entry's pc, and that entry not popped this cycle, SHALL overwrite its taken bit; occupancy unchanged.
REQ-018 If the youngest entry is the head being popped this cycle, a matching accept SHALL be pushed as a new entry.
REQ-019 Full, no pop, non-coalescing accept: incoming outcome dropped, drop_cnt_o increments by 1, saturating at all-ones.
REQ-020 Full with simultaneous pop: accept pushed; level_o stays DEPTH.
REQ-021 Full with coalescing accept: overwrite applied; no drop counted.
REQ-022 Pointers wrap modulo DEPTH; level_o distinguishes full (DEPTH) from empty (0).
REQ-023 flush_i: occupancy becomes 0 next cycle; same-cycle accept discarded, not counted as a drop; drop_cnt_o not cleared.
REQ-024 update_stall_i held: entries retained; accepts continue until full.
REQ-025 debug_mode_i set: queued entries continue to drain normally.

Reset
REQ-026 On rst_ni low, asynchronously: read/write pointers and level_o = 0, drop_cnt_o = 0, bht_update_o = all-zero.
REQ-027 Reset mid-operation SHALL discard all entries; entry storage need not be cleared.
REQ-028 Accepts SHALL begin in the first rising edge after rst_ni deasserts.

Structure
REQ-029 bp_resolve_t, bht_update_t and the cf_t enum SHALL be taken from ariane_pkg, with no new typedefs.
REQ-030 DEPTH and CNT_WIDTH SHALL remain module parameters, not package constants.
REQ-031 No sub-module: storage is inline because coalescing needs tail-entry access that a generic FIFO does not expose.

Verification
REQ-032 Accept pc=0x80 taken=0, stall=0 -> next cycle bht_update_o = {1,0x80,0}, level_o returns to 0.
REQ-033 stall=1, accept pc 0x10,0x20,0x30,0x40,0x50 -> level_o=4, drop_cnt_o=1; release stall -> 0x10..0x40 emitted in order on 4 consecutive cycles.
REQ-034 Accept pc=0x100 taken=1, then pc=0x100 taken=0 while stalled -> level_o=1; single update {0x100,taken=0}.
REQ-035 level_o=3, flush_i with a simultaneous accept -> level_o=0 next cycle, no update emitted, drop_cnt_o unchanged.
REQ-036 cf_type=Jump, or debug_mode_i=1 with a valid branch -> no entry, level_o unchanged.
REQ-037 Preload drop_cnt_o to all-ones, then drop once more -> value stays all-ones.
